card_renderer: RTL and testbench

Pixel-drawing responder for the blackjack game controller's print interface. Accepts draw requests (`writeprint`, `init`, `cardprint`, `orig`), rasterises either a full-screen clear or one 11×19 card, and emits one pixel per cycle to the 160×120 VGA adapter. A one-entry request slot and `waitrequest` give back-pressure; requests that find the slot full are dropped and flagged.

---
 rtl/card_renderer_if.sv | 25 ++
 rtl/card_renderer.sv | 246 ++++++++++++++++++++++++
 tb/tb_card_renderer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_renderer_if.sv
// card_renderer_if: draw-request and VGA pixel bundle between the game
// controller (master) and the card renderer (slave).
interface card_renderer_if;
  logic        writeprint;
  logic        init;
  logic [5:0]  cardprint;
  logic [14:0] orig;
  logic        waitrequest;
  logic        busy;
  logic        overrun;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  modport master (
    output writeprint, init, cardprint, orig,
    input  waitrequest, busy, overrun, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  writeprint, init, cardprint, orig,
    output waitrequest, busy, overrun, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/card_renderer.sv
// card_renderer: rasterises a full-screen green clear or one 11x19 card and
// streams one pixel per cycle to a 160x120 VGA adapter. A one-entry request
// slot provides back-pressure through waitrequest; requests arriving while
// the slot is full are dropped and flagged on the sticky overrun output.
// Optional feature: define CARD_SUIT_PIP_EN to draw a 3x3 suit pip at
// cx 6..8, cy 2..4; without it that area stays white.
module card_renderer (
  input  logic         clk,
  input  logic         rst,
  card_renderer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_CARD} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt_x, cnt_x_nxt;
  logic [6:0]  cnt_y, cnt_y_nxt;
  logic [5:0]  job_code, job_code_nxt;
  logic [14:0] job_orig, job_orig_nxt;

  logic        slot_vld;
  logic        slot_init;
  logic [5:0]  slot_code;
  logic [14:0] slot_orig;

  logic        accept, drop, last_px, take_slot, load_in, fill_slot;

  logic [8:0]  sx;
  logic [7:0]  sy;
  logic [7:0]  px_x;
  logic [6:0]  px_y;
  logic [2:0]  px_colour;
  logic        px_plot;

  logic [7:0]  vga_x_q;
  logic [6:0]  vga_y_q;
  logic [2:0]  vga_colour_q;
  logic        vga_plot_q;
  logic        busy_q;
  logic        overrun_q;

  // 3x5 rank glyphs, rows top-down, MSB of each row is the left pixel.
  function automatic logic [14:0] glyph_rom(input logic [3:0] rank);
    logic [14:0] g;
    case (rank)
      4'd1:    g = 15'h2BED;
      4'd2:    g = 15'h73E7;
      4'd3:    g = 15'h73CF;
      4'd4:    g = 15'h5BC9;
      4'd5:    g = 15'h79CF;
      4'd6:    g = 15'h79EF;
      4'd7:    g = 15'h7249;
      4'd8:    g = 15'h7BEF;
      4'd9:    g = 15'h7BCF;
      4'd10:   g = 15'h7492;
      4'd11:   g = 15'h126F;
      4'd12:   g = 15'h7B79;
      4'd13:   g = 15'h5D35;
      default: g = 15'h0000;
    endcase
    return g;
  endfunction

`ifdef CARD_SUIT_PIP_EN
  // 3x3 suit pips, same row/column packing as the glyphs.
  function automatic logic [8:0] pip_rom(input logic [1:0] suit);
    logic [8:0] p;
    case (suit)
      2'd0:    p = 9'b101_111_010;
      2'd1:    p = 9'b010_111_010;
      2'd2:    p = 9'b111_111_010;
      default: p = 9'b010_111_111;
    endcase
    return p;
  endfunction
`endif

  // Colour of one card pixel at local (cx, cy); earlier rules take priority.
  function automatic logic [2:0] card_colour(input logic [5:0] code,
                                             input logic [3:0] cx,
                                             input logic [4:0] cy);
    logic [3:0]  rank;
    logic [2:0]  suit_col;
    logic [14:0] g;
    logic [3:0]  row, col, gidx;
    logic [2:0]  c;
`ifdef CARD_SUIT_PIP_EN
    logic [8:0]  p;
    logic [3:0]  prow, pcol, pidx;
`endif
    rank     = code[5:2];
    suit_col = code[1] ? 3'b000 : 3'b100;
    g        = glyph_rom(rank);
    row      = cy[3:0] - 4'd2;
    col      = cx - 4'd2;
    gidx     = 4'd14 - (row * 4'd3 + col);
`ifdef CARD_SUIT_PIP_EN
    p        = pip_rom(code[1:0]);
    prow     = cy[3:0] - 4'd2;
    pcol     = cx - 4'd6;
    pidx     = 4'd8 - (prow * 4'd3 + pcol);
`endif
    if (cx == 4'd0 || cx == 4'd10 || cy == 5'd0 || cy == 5'd18)
      c = 3'b000;
    else if (rank == 4'd0 || rank >= 4'd14)
      c = 3'b001;
    else if (cx >= 4'd2 && cx <= 4'd4 && cy >= 5'd2 && cy <= 5'd6 && g[gidx])
      c = suit_col;
`ifdef CARD_SUIT_PIP_EN
    else if (cx >= 4'd6 && cx <= 4'd8 && cy >= 5'd2 && cy <= 5'd4 && p[pidx])
      c = suit_col;
`endif
    else
      c = 3'b111;
    return c;
  endfunction

  // Request routing: straight into an idle engine, otherwise into the slot.
  assign accept    = bus.writeprint && !slot_vld;
  assign drop      = bus.writeprint &&  slot_vld;
  assign last_px   = (state == S_CLEAR && cnt_x == 8'd159 && cnt_y == 7'd119) ||
                     (state == S_CARD  && cnt_x == 8'd10  && cnt_y == 7'd18);
  assign take_slot = slot_vld && (state == S_IDLE || last_px);
  assign load_in   = accept && (state == S_IDLE);
  assign fill_slot = accept && (state != S_IDLE);

  // Engine state register: FSM state, raster counters and slot occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt_x    <= 8'd0;
      cnt_y    <= 7'd0;
      slot_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_x    <= cnt_x_nxt;
      cnt_y    <= cnt_y_nxt;
      if (fill_slot)
        slot_vld <= 1'b1;
      else if (take_slot)
        slot_vld <= 1'b0;
    end
  end

  // Job and slot payloads are only meaningful while qualified by state/slot_vld.
  always_ff @(posedge clk) begin
    job_code <= job_code_nxt;
    job_orig <= job_orig_nxt;
    if (fill_slot) begin
      slot_init <= bus.init;
      slot_code <= bus.cardprint;
      slot_orig <= bus.orig;
    end
  end

  // Next state: load a job (slot first), retire on the last pixel, else advance.
  always_comb begin
    state_nxt    = state;
    cnt_x_nxt    = cnt_x;
    cnt_y_nxt    = cnt_y;
    job_code_nxt = job_code;
    job_orig_nxt = job_orig;
    if (take_slot) begin
      state_nxt    = slot_init ? S_CLEAR : S_CARD;
      cnt_x_nxt    = 8'd0;
      cnt_y_nxt    = 7'd0;
      job_code_nxt = slot_code;
      job_orig_nxt = slot_orig;
    end else if (load_in) begin
      state_nxt    = bus.init ? S_CLEAR : S_CARD;
      cnt_x_nxt    = 8'd0;
      cnt_y_nxt    = 7'd0;
      job_code_nxt = bus.cardprint;
      job_orig_nxt = bus.orig;
    end else if (last_px) begin
      state_nxt = S_IDLE;
    end else if (state == S_CLEAR) begin
      if (cnt_x == 8'd159) begin
        cnt_x_nxt = 8'd0;
        cnt_y_nxt = cnt_y + 7'd1;
      end else begin
        cnt_x_nxt = cnt_x + 8'd1;
      end
    end else if (state == S_CARD) begin
      if (cnt_x == 8'd10) begin
        cnt_x_nxt = 8'd0;
        cnt_y_nxt = cnt_y + 7'd1;
      end else begin
        cnt_x_nxt = cnt_x + 8'd1;
      end
    end
  end

  // Pixel for the upcoming cycle, derived from the next engine position.
  always_comb begin
    sx        = {1'b0, job_orig_nxt[14:7]} + {1'b0, cnt_x_nxt};
    sy        = {1'b0, job_orig_nxt[6:0]}  + {1'b0, cnt_y_nxt};
    px_x      = vga_x_q;
    px_y      = vga_y_q;
    px_colour = vga_colour_q;
    px_plot   = 1'b0;
    case (state_nxt)
      S_CLEAR: begin
        px_x      = cnt_x_nxt;
        px_y      = cnt_y_nxt;
        px_colour = 3'b010;
        px_plot   = 1'b1;
      end
      S_CARD: begin
        px_x      = sx[7:0];
        px_y      = sy[6:0];
        px_colour = card_colour(job_code_nxt, cnt_x_nxt[3:0], cnt_y_nxt[4:0]);
        px_plot   = (sx < 9'd160) && (sy < 8'd120);
      end
      default: ;
    endcase
  end

  // Registered outputs: pixel bus, busy and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      vga_x_q      <= px_x;
      vga_y_q      <= px_y;
      vga_colour_q <= px_colour;
      vga_plot_q   <= px_plot;
      busy_q       <= (state_nxt != S_IDLE);
      overrun_q    <= overrun_q | drop;
    end
  end

  assign bus.waitrequest = slot_vld;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;
  assign bus.vga_x       = vga_x_q;
  assign bus.vga_y       = vga_y_q;
  assign bus.vga_colour  = vga_colour_q;
  assign bus.vga_plot    = vga_plot_q;

endmodule

// File: tb/tb_card_renderer.sv
// tb_card_renderer: scoreboard bench for card_renderer. Stimulus pushes the
// expected pixel stream from a behavioural model; a negedge monitor pops and
// compares every plotted pixel.
module tb_card_renderer;

  logic clk = 1'b0;
  logic rst;
  card_renderer_if bus();

  card_renderer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } px_t;

  localparam logic [14:0] GLYPH [13] = '{
    15'h2BED, 15'h73E7, 15'h73CF, 15'h5BC9, 15'h79CF, 15'h79EF, 15'h7249,
    15'h7BEF, 15'h7BCF, 15'h7492, 15'h126F, 15'h7B79, 15'h5D35};
`ifdef CARD_SUIT_PIP_EN
  localparam logic [8:0] PIP [4] = '{9'b101111010, 9'b010111010,
                                     9'b111111010, 9'b010111111};
`endif

  px_t        exp_q[$];
  logic [2:0] seen [int];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int plot_cnt = 0;
  int last_plot_cyc = 0;
  int last_x = 0;
  int last_y = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every plotted pixel must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.vga_plot) begin
      px_t got, want;
      got = '{x: bus.vga_x, y: bus.vga_y, c: bus.vga_colour};
      plot_cnt++;
      last_plot_cyc = cyc;
      last_x = int'(bus.vga_x);
      last_y = int'(bus.vga_y);
      seen[int'(bus.vga_x) * 128 + int'(bus.vga_y)] = bus.vga_colour;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot got x=%0d y=%0d c=%b required no plot",
                 got.x, got.y, got.c);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL pixel got x=%0d y=%0d c=%b required x=%0d y=%0d c=%b",
                   got.x, got.y, got.c, want.x, want.y, want.c);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  // Reference colour of a card pixel, straight from the drawing rules.
  function automatic logic [2:0] model_colour(input int rank, input int suit,
                                              input int cx, input int cy);
    logic [2:0]  sc;
    logic [14:0] g;
`ifdef CARD_SUIT_PIP_EN
    logic [8:0]  p;
`endif
    sc = (suit < 2) ? 3'b100 : 3'b000;
    if (cx == 0 || cx == 10 || cy == 0 || cy == 18) return 3'b000;
    if (rank == 0 || rank > 13) return 3'b001;
    if (cx >= 2 && cx <= 4 && cy >= 2 && cy <= 6) begin
      g = GLYPH[rank - 1];
      if (((g >> (14 - 3 * (cy - 2) - (cx - 2))) & 15'd1) != 15'd0) return sc;
    end
`ifdef CARD_SUIT_PIP_EN
    if (cx >= 6 && cx <= 8 && cy >= 2 && cy <= 4) begin
      p = PIP[suit];
      if (((p >> (8 - 3 * (cy - 2) - (cx - 6))) & 9'd1) != 9'd0) return sc;
    end
`endif
    return 3'b111;
  endfunction

  task automatic push_card(input logic [5:0] code, input int ox, input int oy,
                           output int n);
    n = 0;
    for (int cy = 0; cy < 19; cy++) begin
      for (int cx = 0; cx < 11; cx++) begin
        int sx, sy;
        sx = ox + cx;
        sy = oy + cy;
        if (sx < 160 && sy < 120) begin
          exp_q.push_back('{x: 8'(sx), y: 7'(sy),
                            c: model_colour(int'(code[5:2]), int'(code[1:0]), cx, cy)});
          n++;
        end
      end
    end
  endtask

  task automatic push_clear();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        exp_q.push_back('{x: 8'(x), y: 7'(y), c: 3'b010});
  endtask

  // Called just after a posedge; holds the request across one edge.
  task automatic issue(input logic i, input logic [5:0] code, input int ox,
                       input int oy, output int acc, output int p0);
    bus.writeprint = 1'b1;
    bus.init       = i;
    bus.cardprint  = code;
    bus.orig       = {8'(ox), 7'(oy)};
    @(posedge clk); #1;
    acc = cyc;
    p0  = plot_cnt;
    bus.writeprint = 1'b0;
    bus.init       = 1'b0;
  endtask

  // Move to the negedge inside cycle k after the accept edge (cycle 1 = first pixel).
  task automatic goto_cycle(input int acc, input int k);
    while (cyc - acc + 1 < k) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  task automatic finish_job(input string nm, input int acc, input int len,
                            input int p0, input int nexp, input bit full_vis);
    goto_cycle(acc, len);
    chk({nm, "_busy_last"}, int'(bus.busy), 1);
    goto_cycle(acc, len + 1);
    chk({nm, "_busy_after"}, int'(bus.busy), 0);
    chk({nm, "_plots"}, plot_cnt - p0, nexp);
    chk({nm, "_pending"}, exp_q.size(), 0);
    if (full_vis) chk({nm, "_last_cycle"}, last_plot_cyc - acc + 1, len);
  endtask

  initial begin
    int acc, p0, n, n2, ox, oy, p;
    logic [5:0] code;

    rst = 1'b1;
    bus.writeprint = 1'b0;
    bus.init = 1'b0;
    bus.cardprint = 6'd0;
    bus.orig = 15'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waitrequest", int'(bus.waitrequest), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    chk("rst_plot", int'(bus.vga_plot), 0);
    chk("rst_xyc", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-screen clear.
    push_clear();
    issue(1'b1, 6'd0, 0, 0, acc, p0);
    finish_job("clear", acc, 19200, p0, 19200, 1'b1);
    chk("clear_last_x", last_x, 159);
    chk("clear_last_y", last_y, 119);

    // Ace of hearts at (2,2).
    @(posedge clk); #1;
    push_card(6'd4, 2, 2, n);
    issue(1'b0, 6'd4, 2, 2, acc, p0);
    finish_job("ace_h", acc, 209, p0, n, 1'b1);
    chk("ace_h_count", n, 209);
    chk("ace_h_2_2", int'(seen[2 * 128 + 2]), 0);
    chk("ace_h_4_4", int'(seen[4 * 128 + 4]), 7);
    chk("ace_h_5_4", int'(seen[5 * 128 + 4]), 4);
    chk("ace_h_12_20", int'(seen[12 * 128 + 20]), 0);

    // Card back at (15,23).
    @(posedge clk); #1;
    push_card(6'd0, 15, 23, n);
    issue(1'b0, 6'd0, 15, 23, acc, p0);
    finish_job("back", acc, 209, p0, n, 1'b1);
    chk("back_20_32", int'(seen[20 * 128 + 32]), 1);
    chk("back_15_23", int'(seen[15 * 128 + 23]), 0);

    // Three back-to-back requests: drawn, held in slot, dropped.
    @(posedge clk); #1;
    push_card(6'd5, 30, 30, n);
    push_card(6'd30, 50, 40, n2);
    issue(1'b0, 6'd5, 30, 30, acc, p0);
    bus.writeprint = 1'b1;
    bus.cardprint  = 6'd30;
    bus.orig       = {8'd50, 7'd40};
    @(posedge clk); #1;
    bus.cardprint  = 6'd51;
    bus.orig       = {8'd70, 7'd50};
    @(posedge clk); #1;
    bus.writeprint = 1'b0;
    @(negedge clk);
    chk("three_waitrequest", int'(bus.waitrequest), 1);
    chk("three_overrun", int'(bus.overrun), 1);
    goto_cycle(acc, 209);
    chk("three_wr_held", int'(bus.waitrequest), 1);
    goto_cycle(acc, 210);
    chk("three_wr_release", int'(bus.waitrequest), 0);
    chk("three_no_gap", int'(bus.vga_plot), 1);
    finish_job("three", acc, 418, p0, n + n2, 1'b1);

    // King of spades clipped at the bottom-right corner.
    @(posedge clk); #1;
    push_card(6'd55, 155, 110, n);
    issue(1'b0, 6'd55, 155, 110, acc, p0);
    finish_job("clip", acc, 209, p0, n, 1'b0);
    chk("clip_count", n, 50);

    // Randomised cards, one at a time.
    for (int k = 0; k < 8; k++) begin
      code = 6'($urandom_range(0, 63));
      ox   = int'($urandom_range(0, 170));
      oy   = int'($urandom_range(0, 125));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      chk("rnd_ready", int'(bus.waitrequest), 0);
      push_card(code, ox, oy, n);
      issue(1'b0, code, ox, oy, acc, p0);
      finish_job("rnd", acc, 209, p0, n, (ox <= 149 && oy <= 101));
    end
    chk("overrun_sticky", int'(bus.overrun), 1);

    // Reset in the middle of a card with a second request waiting in the slot.
    @(posedge clk); #1;
    push_card(6'd40, 60, 60, n);
    issue(1'b0, 6'd40, 60, 60, acc, p0);
    bus.writeprint = 1'b1;
    bus.cardprint  = 6'd44;
    bus.orig       = {8'd90, 7'd70};
    @(posedge clk); #1;
    bus.writeprint = 1'b0;
    goto_cycle(acc, 100);
    chk("mid_plot_before", int'(bus.vga_plot), 1);
    chk("mid_wr_before", int'(bus.waitrequest), 1);
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_plot", int'(bus.vga_plot), 0);
    chk("mid_busy", int'(bus.busy), 0);
    chk("mid_waitrequest", int'(bus.waitrequest), 0);
    chk("mid_overrun", int'(bus.overrun), 0);
    p = plot_cnt;
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("mid_no_plots", plot_cnt - p, 0);
    chk("mid_busy_after", int'(bus.busy), 0);
    chk("mid_wr_after", int'(bus.waitrequest), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
